// File: rtl/morse_player.sv
// rtl/morse_player.sv - plays a buffered Morse word on a lamp; MORSE_PLAYER_REPEAT_EN enables word repeat
module morse_player #(
    parameter int UNIT_CYCLES = 5000000,
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  we,
    input  logic                  en,
    output logic                  morse_led,
    output logic                  busy,
    output logic [3:0]            count,
    output logic                  full
);

    localparam int TW = $clog2(7 * UNIT_CYCLES);
    localparam logic [TW-1:0] LAST_1U = TW'(UNIT_CYCLES - 1);
    localparam logic [TW-1:0] LAST_3U = TW'(3 * UNIT_CYCLES - 1);
`ifdef MORSE_PLAYER_REPEAT_EN
    localparam logic [TW-1:0] LAST_7U = TW'(7 * UNIT_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        IDLE,
        ON,
        SYM_GAP,
        LTR_GAP
`ifdef MORSE_PLAYER_REPEAT_EN
        , WORD_GAP
`endif
    } state_t;

    state_t          state, state_n;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   last_cyc;
    logic            done;
    logic [2:0]      ltr_idx, ltr_n;
    logic [2:0]      sym_idx, sym_n;
    logic [7:0]      letters [8];
    logic [7:0]      cur_ltr;
    logic [2:0]      eff_len;
    logic            cur_sym;
    logic            push_wr, ctrl_wr, clear_wr, run_wr, push_ok;
    logic            unused_bits;
`ifdef MORSE_PLAYER_REPEAT_EN
    logic            run_q, repeat_q;
`endif

    assign unused_bits = ^{data[DATA_WIDTH-1:8], addr[ADDR_WIDTH-1:2]};

    assign push_wr  = en && we && (addr[1:0] == 2'd0);
    assign ctrl_wr  = en && we && (addr[1:0] == 2'd1);
    assign clear_wr = en && we && (addr[1:0] == 2'd2);
    assign run_wr   = ctrl_wr && data[0];
    assign push_ok  = push_wr && !full && (state == IDLE);
    assign full     = (count == 4'd8);

    // Length field is clamped to the 1..5 symbols a letter can hold.
    assign cur_ltr = letters[ltr_idx];
    assign cur_sym = cur_ltr[sym_idx];
    always_comb begin
        eff_len = cur_ltr[7:5];
        if (cur_ltr[7:5] == 3'd0)
            eff_len = 3'd1;
        else if (cur_ltr[7:5] > 3'd5)
            eff_len = 3'd5;
    end

    always_comb begin
        last_cyc = LAST_1U;
        case (state)
            ON:       last_cyc = cur_sym ? LAST_3U : LAST_1U;
            SYM_GAP:  last_cyc = LAST_1U;
            LTR_GAP:  last_cyc = LAST_3U;
`ifdef MORSE_PLAYER_REPEAT_EN
            WORD_GAP: last_cyc = LAST_7U;
`endif
            default:  last_cyc = LAST_1U;
        endcase
    end

    assign done = (timer == last_cyc);

    always_comb begin
        state_n = state;
        ltr_n   = ltr_idx;
        sym_n   = sym_idx;
        case (state)
            IDLE: begin
                if (run_wr && (count != 4'd0)) begin
                    state_n = ON;
                    ltr_n   = 3'd0;
                    sym_n   = 3'd0;
                end
            end
            ON: begin
                if (done) begin
                    if (({1'b0, sym_idx} + 4'd1) < {1'b0, eff_len}) begin
                        state_n = SYM_GAP;
                        sym_n   = sym_idx + 3'd1;
                    end else if (({1'b0, ltr_idx} + 4'd1) < count) begin
                        state_n = LTR_GAP;
                        ltr_n   = ltr_idx + 3'd1;
                        sym_n   = 3'd0;
                    end else begin
`ifdef MORSE_PLAYER_REPEAT_EN
                        if (run_q && repeat_q) begin
                            state_n = WORD_GAP;
                            ltr_n   = 3'd0;
                            sym_n   = 3'd0;
                        end else
`endif
                        state_n = IDLE;
                    end
                end
            end
            SYM_GAP: if (done) state_n = ON;
            LTR_GAP: if (done) state_n = ON;
`ifdef MORSE_PLAYER_REPEAT_EN
            WORD_GAP: if (done) state_n = ON;
`endif
            default: state_n = IDLE;
        endcase
        if (clear_wr)
            state_n = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ltr_idx   <= 3'd0;
            sym_idx   <= 3'd0;
            timer     <= '0;
            morse_led <= 1'b0;
            busy      <= 1'b0;
            count     <= 4'd0;
        end else begin
            state     <= state_n;
            ltr_idx   <= ltr_n;
            sym_idx   <= sym_n;
            timer     <= ((state_n != state) || (state_n == IDLE)) ? '0 : timer + 1'b1;
            morse_led <= (state_n == ON);
            busy      <= (state_n != IDLE);
            if (clear_wr)
                count <= 4'd0;
            else if (push_ok)
                count <= count + 4'd1;
        end
    end

`ifdef MORSE_PLAYER_REPEAT_EN
    // run_q drops on a stop write so the word in flight finishes without repeating.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q    <= 1'b0;
            repeat_q <= 1'b0;
        end else if (clear_wr) begin
            run_q    <= 1'b0;
            repeat_q <= 1'b0;
        end else begin
            if (ctrl_wr)
                repeat_q <= data[1];
            if (state == IDLE)
                run_q <= (state_n == ON);
            else if (ctrl_wr && !data[0])
                run_q <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (push_ok)
            letters[count[2:0]] <= data[7:0];
    end

endmodule

// File: tb/tb_morse_player.sv
// tb/tb_morse_player.sv - self-checking bench for morse_player with UNIT_CYCLES=4
module tb_morse_player;

    localparam int U = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] data = '0;
    logic [15:0] addr = '0;
    logic        we = 1'b0;
    logic        en = 1'b0;
    logic        morse_led;
    logic        busy;
    logic [3:0]  count;
    logic        full;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] word_q [$];
    bit         exp_q  [$];

    morse_player #(.UNIT_CYCLES(U), .DATA_WIDTH(16), .ADDR_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .data(data), .addr(addr), .we(we), .en(en),
        .morse_led(morse_led), .busy(busy), .count(count), .full(full)
    );

    always #5 clk = ~clk;

    // Called at a falling edge; returns at the falling edge after the write was taken.
    task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
        en = 1'b1; we = 1'b1; addr = {14'h0, a}; data = d;
        @(negedge clk);
        en = 1'b0; we = 1'b0;
        addr = 16'($urandom); data = 16'($urandom);
    endtask

    // Lamp pattern from the timing rules: dot 1u, dash 3u, 1u between symbols,
    // 3u between letters, 7u before each repetition of the word.
    function automatic void build_exp(input int reps);
        exp_q.delete();
        for (int r = 0; r < reps; r++) begin
            if (r > 0)
                for (int k = 0; k < 7 * U; k++) exp_q.push_back(1'b0);
            for (int l = 0; l < word_q.size(); l++) begin
                int len;
                len = int'(word_q[l] >> 5);
                if (len == 0) len = 1;
                if (len > 5) len = 5;
                if (l > 0)
                    for (int k = 0; k < 3 * U; k++) exp_q.push_back(1'b0);
                for (int s = 0; s < len; s++) begin
                    if (s > 0)
                        for (int k = 0; k < U; k++) exp_q.push_back(1'b0);
                    for (int k = 0; k < (word_q[l][s] ? 3 * U : U); k++) exp_q.push_back(1'b1);
                end
            end
        end
    endfunction

    task automatic load_word();
        bus_write(2'd2, 16'h0);
        foreach (word_q[i]) bus_write(2'd0, {8'h00, word_q[i]});
    endtask

    // Walks exp_q from the cycle after the run write; optionally issues one write at index wr_at.
    task automatic play_check(input string name, input int wr_at,
                              input logic [1:0] wa, input logic [15:0] wd);
        int   bad;
        logic got_l, got_b;
        bad = -1; got_l = 1'b0; got_b = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (bad < 0 && (morse_led !== exp_q[i] || busy !== 1'b1)) begin
                bad = i; got_l = morse_led; got_b = busy;
            end
            if (i == wr_at) bus_write(wa, wd);
            else @(negedge clk);
        end
        n_checks++;
        if (bad >= 0)
            $display("FAIL %s wave: cycle %0d led=%b busy=%b, required led=%b busy=1",
                     name, bad, got_l, got_b, exp_q[bad]);
        else n_pass++;
        n_checks++;
        if (morse_led !== 1'b0 || busy !== 1'b0)
            $display("FAIL %s end: led=%b busy=%b, required led=0 busy=0", name, morse_led, busy);
        else n_pass++;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({morse_led, busy, count, full} !== 7'b0)
            $display("FAIL reset_held: led=%b busy=%b count=%0d full=%b, required all 0",
                     morse_led, busy, count, full);
        else n_pass++;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({morse_led, busy, count, full} !== 7'b0)
            $display("FAIL reset_release: led=%b busy=%b count=%0d full=%b, required all 0",
                     morse_led, busy, count, full);
        else n_pass++;
    endtask

    task automatic test_letter_a();
        word_q = '{8'h42};
        load_word();
        build_exp(1);
        bus_write(2'd1, 16'h1);
        play_check("letter_a", -1, 2'd0, 16'h0);
    endtask

    task automatic test_e_t();
        word_q = '{8'h20, 8'h21};
        load_word();
        build_exp(1);
        bus_write(2'd1, 16'h1);
        play_check("e_t", -1, 2'd0, 16'h0);
    endtask

    task automatic test_length_clamp();
        word_q = '{8'h01, 8'hF5, 8'hC2};
        load_word();
        build_exp(1);
        bus_write(2'd1, 16'h1);
        play_check("len_clamp", -1, 2'd0, 16'h0);
    endtask

    task automatic test_full();
        bus_write(2'd2, 16'h0);
        for (int i = 0; i < 9; i++) begin
            int want;
            want = (i + 1 > 8) ? 8 : i + 1;
            bus_write(2'd0, 16'($urandom));
            n_checks++;
            if (count !== 4'(want) || full !== (want == 8))
                $display("FAIL full_push%0d: count=%0d full=%b, required count=%0d full=%b",
                         i, count, full, want, (want == 8));
            else n_pass++;
        end
        bus_write(2'd3, 16'hFFFF);
        n_checks++;
        if (count !== 4'd8)
            $display("FAIL addr3_ignored: count=%0d, required 8", count);
        else n_pass++;
        bus_write(2'd2, 16'h0);
        n_checks++;
        if (count !== 4'd0 || full !== 1'b0)
            $display("FAIL full_clear: count=%0d full=%b, required 0 0", count, full);
        else n_pass++;
    endtask

    task automatic test_clear_mid_dash();
        word_q = '{8'h21};
        load_word();
        bus_write(2'd1, 16'h1);
        @(negedge clk);
        n_checks++;
        if (morse_led !== 1'b1)
            $display("FAIL dash_lit: led=%b, required 1", morse_led);
        else n_pass++;
        bus_write(2'd2, 16'h0);
        n_checks++;
        if (morse_led !== 1'b0 || busy !== 1'b0 || count !== 4'd0)
            $display("FAIL clear_mid_dash: led=%b busy=%b count=%0d, required 0 0 0",
                     morse_led, busy, count);
        else n_pass++;
        bus_write(2'd1, 16'h1);
        repeat (3) @(negedge clk);
        n_checks++;
        if (morse_led !== 1'b0 || busy !== 1'b0)
            $display("FAIL run_empty: led=%b busy=%b, required 0 0", morse_led, busy);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int          n, wr_at, kind;
            logic [1:0]  wa;
            logic [15:0] wd;
            string       nm;
            word_q.delete();
            n = int'($urandom_range(1, 8));
            for (int i = 0; i < n; i++) word_q.push_back(8'($urandom));
            load_word();
            n_checks++;
            if (count !== 4'(n))
                $display("FAIL rand%0d_count: count=%0d, required %0d", it, count, n);
            else n_pass++;
            build_exp(1);
            bus_write(2'd1, 16'h1);
            // A push, run, stop or undecoded write mid-word leaves this single play unchanged.
            kind  = int'($urandom_range(0, 3));
            wa    = 2'(kind);
            if (kind == 2) wa = 2'd3;
            wd    = (kind == 1) ? 16'h0001 : (kind == 3) ? 16'h0000 : 16'($urandom);
            if (kind == 3) wa = 2'd1;
            wr_at = int'($urandom_range(0, exp_q.size() - 1));
            nm = $sformatf("rand%0d", it);
            play_check(nm, wr_at, wa, wd);
            n_checks++;
            if (count !== 4'(n))
                $display("FAIL rand%0d_count_after: count=%0d, required %0d", it, count, n);
            else n_pass++;
        end
    endtask

`ifdef MORSE_PLAYER_REPEAT_EN
    task automatic test_repeat();
        word_q = '{8'h20};
        load_word();
        build_exp(3);
        bus_write(2'd1, 16'h3);
        play_check("repeat_stop", U + 7 * U + U + 10, 2'd1, 16'h0);
    endtask
`else
    task automatic test_no_repeat();
        word_q = '{8'h20};
        load_word();
        build_exp(1);
        bus_write(2'd1, 16'h3);
        play_check("no_repeat", -1, 2'd0, 16'h0);
        repeat (10) @(negedge clk);
        n_checks++;
        if (morse_led !== 1'b0 || busy !== 1'b0)
            $display("FAIL no_repeat_idle: led=%b busy=%b, required 0 0", morse_led, busy);
        else n_pass++;
    endtask
`endif

    task automatic test_reset_mid_dash();
        int glitch;
        word_q = '{8'h21};
        load_word();
        bus_write(2'd1, 16'h1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (morse_led !== 1'b0 || busy !== 1'b0 || count !== 4'd0)
            $display("FAIL reset_mid_dash: led=%b busy=%b count=%0d, required 0 0 0",
                     morse_led, busy, count);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        glitch = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (morse_led !== 1'b0 || busy !== 1'b0) glitch++;
        end
        n_checks++;
        if (glitch != 0)
            $display("FAIL reset_release_quiet: %0d active cycles, required 0", glitch);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_letter_a();
        test_e_t();
        test_length_clamp();
        test_full();
        test_clear_mid_dash();
        test_random();
`ifdef MORSE_PLAYER_REPEAT_EN
        test_repeat();
`else
        test_no_repeat();
`endif
        test_reset_mid_dash();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
